// File: rtl/booth_wallace_mul64.sv
// Pipelined 64x64 multiplier: radix-4 Booth partial products, 3:2 carry-save tree
// spread over seven stages, then a final 130-bit carry-propagate add.
module booth_wallace_mul64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    input  logic        block_i,
    input  logic [63:0] op_1_i,
    input  logic [63:0] op_2_i,
    input  logic        sign_op_1_i,
    input  logic        sign_op_2_i,
    output logic [63:0] result_l_o,
    output logic [63:0] result_h_o,
    output logic        ready_o,
    output logic        valid_o
);

    localparam logic [3:0] IDLE   = 4'd0;
    localparam logic [3:0] BUSY_1 = 4'd1;
    localparam logic [3:0] BUSY_8 = 4'd8;
    localparam logic [3:0] LAST   = 4'd9;

    // Row count after each 3:2 level: 33->22->15->10->7->5->4->3->2.
    function automatic int cnt(input int k);
        case (k)
            0:       return 33;
            1:       return 22;
            2:       return 15;
            3:       return 10;
            4:       return 7;
            5:       return 5;
            6:       return 4;
            7:       return 3;
            default: return 2;
        endcase
    endfunction

    function automatic int off(input int k);
        int s;
        s = 0;
        for (int j = 0; j < k; j++) s += cnt(j);
        return s;
    endfunction

    // Level 1 output is not registered, so register and CSA-output spaces skip it.
    function automatic int roff(input int k);
        return (k == 0) ? 0 : off(k) - 22;
    endfunction

    function automatic int coff(input int k);
        return off(k) - 33;
    endfunction

    localparam int TOTAL = 101;
    localparam int NREG  = 79;
    localparam int NCSA  = 68;

    logic [3:0]   state_reg;
    logic [3:0]   state_next;
    logic [64:0]  a_ext;
    logic [64:0]  b_ext;
    logic [66:0]  bx;
    logic [129:0] a_row;
    logic [129:0] pp        [33];
    logic [129:0] tree      [TOTAL];
    logic [129:0] csa       [NCSA];
    logic [129:0] pipe_next [NREG];
    logic [129:0] pipe_reg  [NREG];
    logic [129:0] sum_reg;

    assign a_ext = {sign_op_1_i & op_1_i[63], op_1_i};
    assign b_ext = {sign_op_2_i & op_2_i[63], op_2_i};
    assign bx    = {b_ext[64], b_ext, 1'b0};
    assign a_row = {{65{a_ext[64]}}, a_ext};

    genvar gi, gj;

    // Negative digits are negated in place, so no separate carry-in row is needed.
    generate
        for (gi = 0; gi < 33; gi++) begin : g_booth
            logic [2:0]   digit;
            logic [129:0] mult;
            assign digit = bx[2*gi+2 -: 3];
            always_comb begin
                case (digit)
                    3'b001, 3'b010: mult = a_row;
                    3'b011:         mult = a_row << 1;
                    3'b100:         mult = ~(a_row << 1) + 130'd1;
                    3'b101, 3'b110: mult = ~a_row + 130'd1;
                    default:        mult = '0;
                endcase
            end
            assign pp[gi]        = mult << (2 * gi);
            assign pipe_next[gi] = pp[gi];
            assign tree[gi]      = pipe_reg[gi];
        end

        for (gi = 0; gi < 22; gi++) begin : g_level1_pass
            assign tree[33+gi] = csa[gi];
        end

        for (gi = 2; gi <= 8; gi++) begin : g_stage
            for (gj = 0; gj < cnt(gi); gj++) begin : g_row
                assign pipe_next[roff(gi)+gj] = csa[coff(gi)+gj];
                assign tree[off(gi)+gj]       = pipe_reg[roff(gi)+gj];
            end
        end

        for (gi = 1; gi <= 8; gi++) begin : g_level
            localparam int N = cnt(gi - 1);
            localparam int G = N / 3;
            localparam int R = N % 3;
            localparam int I = off(gi - 1);
            localparam int O = coff(gi);
            for (gj = 0; gj < G; gj++) begin : g_fa
                logic [129:0] x, y, z;
                assign x = tree[I+3*gj];
                assign y = tree[I+3*gj+1];
                assign z = tree[I+3*gj+2];
                assign csa[O+2*gj]   = x ^ y ^ z;
                assign csa[O+2*gj+1] = ((x & y) | (x & z) | (y & z)) << 1;
            end
            for (gj = 0; gj < R; gj++) begin : g_pass
                assign csa[O+2*G+gj] = tree[I+3*G+gj];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < NREG; k++) pipe_reg[k] <= '0;
            sum_reg <= '0;
        end else if (!block_i) begin
            for (int k = 0; k < NREG; k++) pipe_reg[k] <= pipe_next[k];
            sum_reg <= tree[TOTAL-2] + tree[TOTAL-1];
        end
    end

    always_comb begin
        state_next = state_reg;
        if (block_i)
            state_next = IDLE;
        else if (state_reg == IDLE)
            state_next = req_valid_i ? BUSY_1 : IDLE;
        else if (state_reg == LAST)
            state_next = IDLE;
        else
            state_next = state_reg + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst) state_reg <= IDLE;
        else      state_reg <= state_next;
    end

    assign ready_o    = (state_reg == IDLE) ? ~req_valid_i : (state_reg == BUSY_8 || state_reg == LAST);
    assign valid_o    = (state_reg == IDLE) ? ~req_valid_i : (state_reg == LAST);
    assign result_l_o = sum_reg[63:0];
    assign result_h_o = sum_reg[127:64];

endmodule

// File: tb/tb_booth_wallace_mul64.sv
// Directed and random checks of the pipelined Booth/Wallace multiplier against
// a plain 130-bit arithmetic product of the extended operands.
module tb_booth_wallace_mul64;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        block_i = 1'b0;
    logic [63:0] op_1_i = '0;
    logic [63:0] op_2_i = '0;
    logic        sign_op_1_i = 1'b0;
    logic        sign_op_2_i = 1'b0;
    logic [63:0] result_l_o;
    logic [63:0] result_h_o;
    logic        ready_o;
    logic        valid_o;

    int errors = 0;
    int checks = 0;

    booth_wallace_mul64 dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (req_valid_i),
        .block_i     (block_i),
        .op_1_i      (op_1_i),
        .op_2_i      (op_2_i),
        .sign_op_1_i (sign_op_1_i),
        .sign_op_2_i (sign_op_2_i),
        .result_l_o  (result_l_o),
        .result_h_o  (result_h_o),
        .ready_o     (ready_o),
        .valid_o     (valid_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] model(input logic [63:0] a, input logic [63:0] b,
                                           input logic sa, input logic sb);
        logic [129:0] ea, eb, p;
        ea = {{66{sa & a[63]}}, a};
        eb = {{66{sb & b[63]}}, b};
        p  = ea * eb;
        return p[127:0];
    endfunction

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble_ops();
        op_1_i      = {$urandom, $urandom};
        op_2_i      = {$urandom, $urandom};
        sign_op_1_i = 1'($urandom_range(0, 1));
        sign_op_2_i = 1'($urandom_range(0, 1));
    endtask

    // Issue one request and follow it through all nine busy states.
    task automatic run_mul(input logic [63:0] a, input logic [63:0] b,
                           input logic sa, input logic sb, input string tag);
        logic [127:0] exp;
        logic [127:0] got;
        exp = model(a, b, sa, sb);
        op_1_i = a; op_2_i = b; sign_op_1_i = sa; sign_op_2_i = sb;
        req_valid_i = 1'b1;
        #1;
        chk({tag, "_accept_ready"}, 128'(ready_o), 128'(0));
        chk({tag, "_accept_valid"}, 128'(valid_o), 128'(0));
        edge_step();
        req_valid_i = 1'b0;
        scramble_ops();
        got = '0;
        for (int k = 1; k <= 9; k++) begin
            #1;
            chk($sformatf("%s_ready_s%0d", tag, k), 128'(ready_o), 128'(k >= 8));
            chk($sformatf("%s_valid_s%0d", tag, k), 128'(valid_o), 128'(k == 9));
            if (k == 9) begin
                got = {result_h_o, result_l_o};
                chk({tag, "_product"}, got, exp);
            end
            edge_step();
            scramble_ops();
        end
        #1;
        chk({tag, "_idle_ready"}, 128'(ready_o), 128'(1));
        chk({tag, "_idle_valid"}, 128'(valid_o), 128'(1));
        $display("txn %s a=%h b=%h sa=%0d sb=%0d got=%h exp=%h", tag, a, b, sa, sb, got, exp);
    endtask

    task automatic start_only(input int busy_edges);
        op_1_i = {$urandom, $urandom};
        op_2_i = {$urandom, $urandom};
        req_valid_i = 1'b1;
        edge_step();
        req_valid_i = 1'b0;
        for (int k = 1; k < busy_edges; k++) edge_step();
    endtask

    initial begin
        logic [63:0] ra, rb;
        int sel;

        rst = 1'b0;
        edge_step();
        edge_step();
        #1;
        chk("reset_ready", 128'(ready_o), 128'(1));
        chk("reset_valid", 128'(valid_o), 128'(1));
        chk("reset_result", {result_h_o, result_l_o}, 128'(0));
        rst = 1'b1;
        edge_step();

        run_mul(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, "umax");
        run_mul(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, "sneg1");
        run_mul(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, "mixed");
        run_mul(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 1'b1, "smin");
        run_mul(64'd3, 64'd5, 1'b0, 1'b0, "small");
        run_mul(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, "umin_sneg");

        // Abort from state 4; the next request must still complete cleanly.
        start_only(4);
        block_i = 1'b1;
        edge_step();
        block_i = 1'b0;
        #1;
        chk("block_ready", 128'(ready_o), 128'(1));
        chk("block_valid_idle", 128'(valid_o), 128'(1));
        edge_step();
        #1;
        chk("block_stays_idle", 128'(ready_o), 128'(1));
        run_mul(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1, 1'b0, "after_block");

        start_only(3);
        rst = 1'b0;
        edge_step();
        #1;
        chk("midreset_ready", 128'(ready_o), 128'(1));
        chk("midreset_valid", 128'(valid_o), 128'(1));
        chk("midreset_result", {result_h_o, result_l_o}, 128'(0));
        rst = 1'b1;
        edge_step();
        run_mul(64'hDEAD_BEEF_0000_0007, 64'h0000_0000_0000_0009, 1'b1, 1'b1, "after_reset");

        for (int i = 0; i < 16; i++) begin
            sel = $urandom_range(0, 3);
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if (sel == 1) ra = 64'h8000_0000_0000_0000;
            if (sel == 2) rb = 64'hFFFF_FFFF_FFFF_FFFF;
            run_mul(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    $sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/booth_wallace_mul64.md
Name: booth_wallace_mul64

Overview:
- Pipelined 64x64 integer multiplier with a full 128-bit product.
- Each operand is independently signed or unsigned.
- Datapath: radix-4 (Booth-2) partial-product generation, a 130-bit 3:2 carry-save adder tree, and a final carry-propagate adder.
- Pipeline registers sit between tree levels. A small FSM sequences one request at a time.
- Sits beside the integer pipeline as a multi-cycle MUL unit with a ready/valid-style interface.

Parameters:
- none. All widths are fixed: 64-bit operands, 65-bit extended operands, 130-bit internal rows.

Ports:
- clk  in  1  clock, all state updates on the rising edge
- rst  in  1  synchronous active-low reset
- req_valid_i  in  1  request strobe; sampled only in IDLE
- block_i  in  1  stall/flush: freezes datapath registers and forces the FSM to IDLE
- op_1_i  in  64  multiplicand
- op_2_i  in  64  multiplier
- sign_op_1_i  in  1  1 = op_1_i is two's complement, 0 = unsigned
- sign_op_2_i  in  1  1 = op_2_i is two's complement, 0 = unsigned
- result_l_o  out  64  product bits [63:0]
- result_h_o  out  64  product bits [127:64]
- ready_o  out  1  unit can accept or complete a request
- valid_o  out  1  result is valid

Behaviour:
- Operand extension: each operand becomes 65 bits. The extra top bit is the copy of bit 63 when its sign flag is 1, otherwise 0.
- Product: the exact 130-bit two's-complement product of the extended operands. Outputs are bits [127:0] of it.
- Booth-2 encoding:
  - Multiplier is extended with an implicit 0 below bit 0, then sign-extended to an even width; this gives 33 digits.
  - Each digit is in {-2,-1,0,+1,+2}. Each partial product is the 130-bit sign-extended multiple shifted left by 2i.
  - Negation is by invert plus carry-in, folded into the row or the tree.
- Pipeline: exactly 9 register stages.
  - Stage 1: Booth partial products.
  - Stages 2-8: CSA reduction 33→2. A stage may contain more than one 3:2 level, so the eight levels 33→22→15→10→7→5→4→3→2 fit in 7 stages.
  - Stage 9: final 130-bit add.
  - All are 130-bit registers, reset value 0.
  - Write enable is ~block_i. Registers load every cycle otherwise, independent of the FSM.
- FSM: 4-bit state register with reset value 0.
  - State 0 is IDLE; states 1..9 are BUSY.
  - Its register is always enabled.
  - next = 0 if block_i=1.
  - Else, in state 0: next = 1 if req_valid_i=1, otherwise stay 0.
  - Else, in state 9: next = 0.
  - Else: next = state+1.
- Operand capture: operands present in the cycle the request is accepted (state 0, req_valid_i=1, block_i=0) enter stage 1 on that edge.
- Latency: the product appears on result_*_o in state 9, i.e. 9 rising edges after acceptance.
- ready_o:
  - state 0: ~req_valid_i
  - state 8 or 9: 1
  - otherwise: 0
- valid_o:
  - state 0: ~req_valid_i
  - state 9: 1
  - otherwise: 0
- Result outputs: meaningful only when state=9. Outside that state they reflect the pipeline contents and the bench must not check them.
- Requests outside state 0: ignored. A request in state 9 is not accepted; the FSM returns to 0 first.
- block_i while busy: aborts the operation. The FSM is in state 0 next cycle and datapath registers hold their values. The stale result is never flagged valid.
- Reset: synchronous active-low. All datapath registers are 0 and the state is 0. After reset with req_valid_i=0: ready_o=1, valid_o=1, results 0.

Test Plan:
- Unsigned 0xFFFFFFFFFFFFFFFF × 0xFFFFFFFFFFFFFFFF, both sign flags 0, req for 1 cycle → at state 9 (9 edges later): valid_o=1, result_h_o=0xFFFFFFFFFFFFFFFE, result_l_o=0x0000000000000001.
- Signed -1 × -1, both sign flags 1 → result_h_o=0, result_l_o=1. Mixed case: op_1=-1 signed × 0xFFFFFFFFFFFFFFFF unsigned → result_h_o=0xFFFFFFFFFFFFFFFF, result_l_o=0x0000000000000001.
- Signed 0x8000000000000000 × 0x8000000000000000 → result_h_o=0x4000000000000000, result_l_o=0. Also 3 × 5 unsigned → result_l_o=15, result_h_o=0.
- Handshake sequence after req → ready_o=0/valid_o=0 in states 1-7; ready_o=1/valid_o=0 in state 8; both 1 in state 9; back in IDLE the next cycle.
- block_i asserted in state 4 → state 0 on the next edge, ready_o=1, and no valid pulse. A fresh request then completes correctly 9 edges later.
- rst=0 held mid-operation → state 0 and result outputs 0 after the edge. A new request after release returns the correct product.
